// File: rtl/ucsbece154b_pipe_ctrl_pkg.sv
// rtl/ucsbece154b_pipe_ctrl_pkg.sv - shared decode encodings and control bundle for the pipeline control unit
package ucsbece154b_pipe_ctrl_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_IMMEXT = 2'b11;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       branchNe;
        logic [2:0] aluControl;
        logic       aluSrc;
    } ctrl_t;

    // M stage has the newest value, so it outranks W.
    function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdM,
                                          input logic [4:0] rdW, input logic regWriteM,
                                          input logic regWriteW);
        if (regWriteM && rs != 5'd0 && rs == rdM)
            return FWD_MEM;
        else if (regWriteW && rs != 5'd0 && rs == rdW)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/ucsbece154b_hazard.sv
// rtl/ucsbece154b_hazard.sv - combinational stall, flush and forwarding selects
module ucsbece154b_hazard
    import ucsbece154b_pipe_ctrl_pkg::*;
(
    input  logic [4:0] Rs1D_i,
    input  logic [4:0] Rs2D_i,
    input  logic [4:0] Rs1E_i,
    input  logic [4:0] Rs2E_i,
    input  logic [4:0] RdE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic [1:0] ResultSrcE_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    input  logic       PCSrcE_i,
    output logic       StallF_o,
    output logic       StallD_o,
    output logic       FlushD_o,
    output logic       FlushE_o,
    output logic [1:0] ForwardAE_o,
    output logic [1:0] ForwardBE_o
);

    logic lwStall;

    assign lwStall = (ResultSrcE_i == RES_MEM) && (RdE_i != 5'd0) &&
                     ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

    // A redirect discards the D instruction, so holding F/D would only lose the new PC.
    assign StallF_o = lwStall & ~PCSrcE_i;
    assign StallD_o = lwStall & ~PCSrcE_i;
    assign FlushD_o = PCSrcE_i;
    assign FlushE_o = lwStall | PCSrcE_i;

    assign ForwardAE_o = fwdSel(Rs1E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);
    assign ForwardBE_o = fwdSel(Rs2E_i, RdM_i, RdW_i, RegWriteM_i, RegWriteW_i);

endmodule

// File: rtl/ucsbece154b_pipe_ctrl.sv
// rtl/ucsbece154b_pipe_ctrl.sv - decode, control pipeline and hazard unit; UCSBECE154B_PERF_CNT_EN adds perf counters
module ucsbece154b_pipe_ctrl
    import ucsbece154b_pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic [4:0]       RdM_i,
    input  logic [4:0]       RdW_i,
    input  logic             ZeroE_i,
    output logic [2:0]       ImmSrcD_o,
    output logic             ALUSrcE_o,
    output logic [2:0]       ALUControlE_o,
    output logic             PCSrcE_o,
    output logic             MemWriteM_o,
    output logic [1:0]       ResultSrcM_o,
    output logic [1:0]       ResultSrcW_o,
    output logic             RegWriteW_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o
`ifdef UCSBECE154B_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    ctrl_t      ctrlD, ctrlE;
    logic [2:0] immSrcD;
    logic       regWriteM, memWriteM, regWriteW;
    logic [1:0] resultSrcM, resultSrcW;

    always_comb begin
        ctrlD   = '0;
        immSrcD = IMM_I;
        case (op_i)
            OP_LW: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.aluSrc    = 1'b1;
                ctrlD.resultSrc = RES_MEM;
            end
            OP_SW: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                immSrcD        = IMM_S;
            end
            OP_R, OP_I: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc   = (op_i == OP_I);
                case (funct3_i)
                    3'b000:  ctrlD.aluControl = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  ctrlD.aluControl = ALU_AND;
                    3'b110:  ctrlD.aluControl = ALU_OR;
                    3'b010:  ctrlD.aluControl = ALU_SLT;
                    default: ctrlD.aluControl = ALU_ADD;
                endcase
            end
            OP_B: begin
                if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
                    ctrlD.branch     = 1'b1;
                    ctrlD.branchNe   = funct3_i[0];
                    ctrlD.aluControl = ALU_SUB;
                    immSrcD          = IMM_B;
                end
            end
            OP_JAL: begin
                ctrlD.jump      = 1'b1;
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                immSrcD         = IMM_J;
            end
            OP_LUI: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_IMMEXT;
                immSrcD         = IMM_U;
            end
            default: begin
                ctrlD   = '0;
                immSrcD = IMM_I;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrlE <= '0;
        else if (FlushE_o)
            ctrlE <= '0;
        else
            ctrlE <= ctrlD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteM  <= 1'b0;
            resultSrcM <= RES_ALU;
            memWriteM  <= 1'b0;
            regWriteW  <= 1'b0;
            resultSrcW <= RES_ALU;
        end else begin
            regWriteM  <= ctrlE.regWrite;
            resultSrcM <= ctrlE.resultSrc;
            memWriteM  <= ctrlE.memWrite;
            regWriteW  <= regWriteM;
            resultSrcW <= resultSrcM;
        end
    end

    assign ImmSrcD_o     = immSrcD;
    assign ALUSrcE_o     = ctrlE.aluSrc;
    assign ALUControlE_o = ctrlE.aluControl;
    assign PCSrcE_o      = ctrlE.jump | (ctrlE.branch & (ZeroE_i ^ ctrlE.branchNe));
    assign MemWriteM_o   = memWriteM;
    assign ResultSrcM_o  = resultSrcM;
    assign ResultSrcW_o  = resultSrcW;
    assign RegWriteW_o   = regWriteW;

    ucsbece154b_hazard u_hazard (
        .Rs1D_i       (Rs1D_i),
        .Rs2D_i       (Rs2D_i),
        .Rs1E_i       (Rs1E_i),
        .Rs2E_i       (Rs2E_i),
        .RdE_i        (RdE_i),
        .RdM_i        (RdM_i),
        .RdW_i        (RdW_i),
        .ResultSrcE_i (ctrlE.resultSrc),
        .RegWriteM_i  (regWriteM),
        .RegWriteW_i  (regWriteW),
        .PCSrcE_i     (PCSrcE_o),
        .StallF_o     (StallF_o),
        .StallD_o     (StallD_o),
        .FlushD_o     (FlushD_o),
        .FlushE_o     (FlushE_o),
        .ForwardAE_o  (ForwardAE_o),
        .ForwardBE_o  (ForwardBE_o)
    );

`ifdef UCSBECE154B_PERF_CNT_EN
    logic validE, validM, validW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validE        <= 1'b0;
            validM        <= 1'b0;
            validW        <= 1'b0;
            cycle_cnt_o   <= '0;
            retired_cnt_o <= '0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            validE      <= FlushE_o ? 1'b0 : (op_i != 7'd0);
            validM      <= validE;
            validW      <= validM;
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (validW)
                retired_cnt_o <= retired_cnt_o + 1'b1;
            if (StallD_o)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (PCSrcE_o)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_pipe_ctrl.sv
// tb/tb_ucsbece154b_pipe_ctrl.sv - self-checking bench for the pipeline control unit
module tb_ucsbece154b_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic       ZeroE_i;
    logic [2:0] ImmSrcD_o, ALUControlE_o;
    logic       ALUSrcE_o, PCSrcE_o, MemWriteM_o, RegWriteW_o;
    logic [1:0] ResultSrcM_o, ResultSrcW_o, ForwardAE_o, ForwardBE_o;
    logic       StallF_o, StallD_o, FlushD_o, FlushE_o;
`ifdef UCSBECE154B_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, retired_cnt_o, stall_cnt_o, flush_cnt_o;
`endif

    // standalone hazard unit to reach the stall/redirect overlap directly
    logic [4:0] hRs1D, hRs2D, hRs1E, hRs2E, hRdE, hRdM, hRdW;
    logic [1:0] hResSrcE, hFwdA, hFwdB;
    logic       hRwM, hRwW, hPcSrc, hStallF, hStallD, hFlushD, hFlushE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucsbece154b_pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op_i(op_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i), .RdE_i(RdE_i),
        .RdM_i(RdM_i), .RdW_i(RdW_i), .ZeroE_i(ZeroE_i), .ImmSrcD_o(ImmSrcD_o),
        .ALUSrcE_o(ALUSrcE_o), .ALUControlE_o(ALUControlE_o), .PCSrcE_o(PCSrcE_o),
        .MemWriteM_o(MemWriteM_o), .ResultSrcM_o(ResultSrcM_o), .ResultSrcW_o(ResultSrcW_o),
        .RegWriteW_o(RegWriteW_o), .StallF_o(StallF_o), .StallD_o(StallD_o),
        .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .ForwardAE_o(ForwardAE_o),
        .ForwardBE_o(ForwardBE_o)
`ifdef UCSBECE154B_PERF_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o), .retired_cnt_o(retired_cnt_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    ucsbece154b_hazard u_hz (
        .Rs1D_i(hRs1D), .Rs2D_i(hRs2D), .Rs1E_i(hRs1E), .Rs2E_i(hRs2E), .RdE_i(hRdE),
        .RdM_i(hRdM), .RdW_i(hRdW), .ResultSrcE_i(hResSrcE), .RegWriteM_i(hRwM),
        .RegWriteW_i(hRwW), .PCSrcE_i(hPcSrc), .StallF_o(hStallF), .StallD_o(hStallD),
        .FlushD_o(hFlushD), .FlushE_o(hFlushE), .ForwardAE_o(hFwdA), .ForwardBE_o(hFwdB)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] imm;
        logic       aluSrc;
        logic [2:0] alu;
        logic       pcSrc;
        logic       memWrite;
        logic [1:0] resSrc;
        logic       regWrite;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        op_i = op; funct3_i = f3; funct7b5_i = f7; Rs1D_i = rs1; Rs2D_i = rs2;
    endtask

    task automatic setRegs(input logic [4:0] rs1e, input logic [4:0] rs2e, input logic [4:0] rde,
                           input logic [4:0] rdm, input logic [4:0] rdw);
        Rs1E_i = rs1e; Rs2E_i = rs2e; RdE_i = rde; RdM_i = rdm; RdW_i = rdw;
    endtask

    task automatic drain();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        ZeroE_i = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0]  = '{"lw",   7'b0000011, 3'b010, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1};
        vecs[1]  = '{"sw",   7'b0100011, 3'b010, 1'b0, 3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[2]  = '{"add",  7'b0110011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[3]  = '{"sub",  7'b0110011, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[4]  = '{"and",  7'b0110011, 3'b111, 1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[5]  = '{"or",   7'b0110011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[6]  = '{"slt",  7'b0110011, 3'b010, 1'b0, 3'b000, 1'b0, 3'b101, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[7]  = '{"addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[8]  = '{"andi", 7'b0010011, 3'b111, 1'b0, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[9]  = '{"ori",  7'b0010011, 3'b110, 1'b0, 3'b000, 1'b1, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[10] = '{"slti", 7'b0010011, 3'b010, 1'b0, 3'b000, 1'b1, 3'b101, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[11] = '{"beq",  7'b1100011, 3'b000, 1'b0, 3'b010, 1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[12] = '{"bne",  7'b1100011, 3'b001, 1'b0, 3'b010, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[13] = '{"jal",  7'b1101111, 3'b000, 1'b0, 3'b011, 1'b0, 3'b000, 1'b1, 1'b0, 2'b10, 1'b1};
        vecs[14] = '{"lui",  7'b0110111, 3'b000, 1'b0, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[15] = '{"bad",  7'b1111111, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0};

        hRs1D = 0; hRs2D = 0; hRs1E = 0; hRs2E = 0; hRdE = 0; hRdM = 0; hRdW = 0;
        hResSrcE = 0; hRwM = 0; hRwW = 0; hPcSrc = 0;

        reset = 1'b1;
        ZeroE_i = 1'b0;
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) step();
        chk("rst_imm", ImmSrcD_o, 0);
        chk("rst_alusrc", ALUSrcE_o, 0);
        chk("rst_aluctl", ALUControlE_o, 0);
        chk("rst_pcsrc", PCSrcE_o, 0);
        chk("rst_memwrite", MemWriteM_o, 0);
        chk("rst_resm", ResultSrcM_o, 0);
        chk("rst_resw", ResultSrcW_o, 0);
        chk("rst_regwrite", RegWriteW_o, 0);
        chk("rst_stall", {StallF_o, StallD_o, FlushD_o, FlushE_o}, 0);
        chk("rst_fwd", {ForwardAE_o, ForwardBE_o}, 0);
        reset = 1'b0;

        // add x3,x1,x2 reaches W three cycles later
        setD(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        step(); step();
        chk("add_regwrite_w", RegWriteW_o, 1);
        chk("add_ressrc_w", ResultSrcW_o, 2'b00);
        drain();

        for (int i = 0; i < 16; i++) begin
            setD(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd0, 5'd0);
            #1;
            chk({vecs[i].name, "_imm"}, ImmSrcD_o, vecs[i].imm);
            step();
            setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
            #1;
            chk({vecs[i].name, "_alusrc"}, ALUSrcE_o, vecs[i].aluSrc);
            chk({vecs[i].name, "_aluctl"}, ALUControlE_o, vecs[i].alu);
            chk({vecs[i].name, "_pcsrc"}, PCSrcE_o, vecs[i].pcSrc);
            step();
            chk({vecs[i].name, "_memwrite"}, MemWriteM_o, vecs[i].memWrite);
            chk({vecs[i].name, "_resm"}, ResultSrcM_o, vecs[i].resSrc);
            step();
            chk({vecs[i].name, "_regwrite"}, RegWriteW_o, vecs[i].regWrite);
            chk({vecs[i].name, "_resw"}, ResultSrcW_o, vecs[i].resSrc);
            drain();
        end

        // load-use: lw x5,0(x0) then add x6,x5,x1
        setD(7'b0000011, 3'b010, 1'b0, 5'd0, 5'd0);
        step();
        setD(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd1);
        setRegs(5'd0, 5'd0, 5'd5, 5'd0, 5'd0);
        #1;
        chk("lu_stall", {StallF_o, StallD_o, FlushE_o, FlushD_o}, 4'b1110);
        step();
        setRegs(5'd0, 5'd0, 5'd0, 5'd5, 5'd0);
        #1;
        chk("lu_stall_once", {StallF_o, StallD_o, FlushE_o}, 3'b000);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd5, 5'd1, 5'd6, 5'd0, 5'd5);
        #1;
        chk("lu_fwd_a", ForwardAE_o, 2'b01);
        chk("lu_fwd_b", ForwardBE_o, 2'b00);
        drain();

        // add x7,x1,x2 ; sub x8,x7,x7
        setD(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2);
        step();
        setD(7'b0110011, 3'b000, 1'b1, 5'd7, 5'd7);
        setRegs(5'd1, 5'd2, 5'd7, 5'd0, 5'd0);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd7, 5'd7, 5'd8, 5'd7, 5'd0);
        #1;
        chk("b2b_fwd", {ForwardAE_o, ForwardBE_o}, 4'b1010);
        chk("b2b_aluctl", ALUControlE_o, 3'b001);
        drain();

        // add x0,... ; sub x8,x0,x0 must not forward
        setD(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2);
        step();
        setD(7'b0110011, 3'b000, 1'b1, 5'd0, 5'd0);
        setRegs(5'd1, 5'd2, 5'd0, 5'd0, 5'd0);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd8, 5'd0, 5'd0);
        #1;
        chk("x0_fwd", {ForwardAE_o, ForwardBE_o}, 4'b0000);
        drain();

        // beq taken
        setD(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        ZeroE_i = 1'b1;
        #1;
        chk("beq_taken", {PCSrcE_o, FlushD_o, FlushE_o}, 3'b111);
        step();
        chk("beq_one_cycle", {PCSrcE_o, FlushD_o, FlushE_o}, 3'b000);
        drain();

        // bne with equal operands is not taken
        setD(7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        ZeroE_i = 1'b1;
        #1;
        chk("bne_not_taken", {PCSrcE_o, FlushD_o, FlushE_o}, 3'b000);
        drain();

        // jal in E while D reads jal's rd
        setD(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0);
        step();
        setD(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd3);
        setRegs(5'd0, 5'd0, 5'd1, 5'd0, 5'd0);
        #1;
        chk("jal_redirect", {PCSrcE_o, StallF_o, StallD_o, FlushE_o}, 4'b1001);
        drain();

        // asynchronous reset mid-stream
        setD(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd0);
        step();
        setD(7'b0000011, 3'b010, 1'b0, 5'd0, 5'd0);
        step();
        chk("async_pre", {MemWriteM_o, ALUSrcE_o}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("async_rst", {MemWriteM_o, ALUSrcE_o, ResultSrcM_o}, 4'b0000);
        #1 reset = 1'b0;
        drain();

        // hazard unit: load-use coinciding with a redirect
        hResSrcE = 2'b01; hRdE = 5'd5; hRs1D = 5'd5; hPcSrc = 1'b1;
        #1;
        chk("hz_overlap", {hStallF, hStallD, hFlushD, hFlushE}, 4'b0011);
        hPcSrc = 1'b0;
        #1;
        chk("hz_lustall", {hStallF, hStallD, hFlushD, hFlushE}, 4'b1101);
        hRdE = 5'd0; hRs1D = 5'd0;
        #1;
        chk("hz_rd0", {hStallF, hStallD, hFlushE}, 3'b000);
        hRs1E = 5'd3; hRs2E = 5'd3; hRdM = 5'd3; hRdW = 5'd3; hRwM = 1'b1; hRwW = 1'b1;
        #1;
        chk("hz_prio", {hFwdA, hFwdB}, 4'b1010);
        hRwM = 1'b0;
        #1;
        chk("hz_wb", {hFwdA, hFwdB}, 4'b0101);

`ifdef UCSBECE154B_PERF_CNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        setD(7'b0000011, 3'b010, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        setD(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd1);
        setRegs(5'd0, 5'd0, 5'd5, 5'd0, 5'd0);
        step();
        setRegs(5'd0, 5'd0, 5'd0, 5'd5, 5'd0);
        step();
        setD(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0);
        setRegs(5'd5, 5'd1, 5'd6, 5'd0, 5'd5);
        step();
        setD(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd7, 5'd6, 5'd0);
        step();
        setD(7'd0, 3'd0, 1'b0, 5'd0, 5'd0);
        setRegs(5'd0, 5'd0, 5'd0, 5'd7, 5'd6);
        step();
        setRegs(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (4) step();
        chk("perf_cycles", cycle_cnt_o, 10);
        chk("perf_stalls", stall_cnt_o, 1);
        chk("perf_retired", retired_cnt_o, 4);
        chk("perf_flushes", flush_cnt_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
